// File: rtl/uart_transceiver.sv
// rtl/uart_transceiver.sv - full-duplex 8N1 UART sharing one 16x oversampling baud tick
// Optional: define UART_RX_SYNC_EN to put a two-flop synchroniser in front of the RX FSM.
module uart_transceiver #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int BAUD     = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  input  logic       rx,
  output logic       tx,
  output logic       tx_busy,
  output logic [7:0] rx_data,
  output logic       rx_busy,
  output logic       rx_done
);
  localparam int TICK_DIV = CLK_FREQ / (BAUD * 16);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [TW-1:0] tick_cnt;
  logic          tick;
  logic          rx_s;

  state_t     tx_state, rx_state;
  logic [3:0] tx_tick, rx_tick;
  logic [2:0] tx_bit, rx_bit;
  logic [7:0] tx_shift, rx_shift;

  assign tick = (tick_cnt == TICK_LAST);

  always_ff @(posedge clk) begin
    if (!reset)    tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + TW'(1);
  end

`ifdef UART_RX_SYNC_EN
  logic [1:0] rx_sync;
  always_ff @(posedge clk) begin
    if (!reset) rx_sync <= 2'b11;
    else        rx_sync <= {rx_sync[0], rx};
  end
  assign rx_s = rx_sync[1];
`else
  assign rx_s = rx;
`endif

  // The 4-bit tick counters wrap 15->0, which marks each 16-tick bit boundary.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_state <= S_IDLE;
      tx_tick  <= 4'd0;
      tx_bit   <= 3'd0;
      tx_shift <= 8'h00;
      tx       <= 1'b1;
      tx_busy  <= 1'b0;
    end else begin
      case (tx_state)
        S_IDLE: if (tx_start) begin
          tx_shift <= tx_data;
          tx_tick  <= 4'd0;
          tx_bit   <= 3'd0;
          tx       <= 1'b0;
          tx_busy  <= 1'b1;
          tx_state <= S_START;
        end
        S_START: if (tick) begin
          tx_tick <= tx_tick + 4'd1;
          if (tx_tick == 4'd15) begin
            tx       <= tx_shift[0];
            tx_state <= S_DATA;
          end
        end
        S_DATA: if (tick) begin
          tx_tick <= tx_tick + 4'd1;
          if (tx_tick == 4'd15) begin
            tx_shift <= {1'b1, tx_shift[7:1]};
            tx_bit   <= tx_bit + 3'd1;
            if (tx_bit == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx <= tx_shift[1];
            end
          end
        end
        S_STOP: if (tick) begin
          tx_tick <= tx_tick + 4'd1;
          if (tx_tick == 4'd15) begin
            tx_busy  <= 1'b0;
            tx_state <= S_IDLE;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_state <= S_IDLE;
      rx_tick  <= 4'd0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
      rx_data  <= 8'h00;
      rx_busy  <= 1'b0;
      rx_done  <= 1'b0;
    end else begin
      rx_done <= 1'b0;
      case (rx_state)
        S_IDLE: if (!rx_s) begin
          rx_tick  <= 4'd0;
          rx_bit   <= 3'd0;
          rx_busy  <= 1'b1;
          rx_state <= S_START;
        end
        // Half a bit in: a line that has gone high again was only a glitch.
        S_START: if (tick) begin
          rx_tick <= rx_tick + 4'd1;
          if (rx_tick == 4'd7) begin
            rx_tick <= 4'd0;
            if (rx_s) begin
              rx_busy  <= 1'b0;
              rx_state <= S_IDLE;
            end else begin
              rx_state <= S_DATA;
            end
          end
        end
        S_DATA: if (tick) begin
          rx_tick <= rx_tick + 4'd1;
          if (rx_tick == 4'd15) begin
            rx_shift <= {rx_s, rx_shift[7:1]};
            rx_bit   <= rx_bit + 3'd1;
            if (rx_bit == 3'd7) rx_state <= S_STOP;
          end
        end
        S_STOP: if (tick) begin
          rx_tick <= rx_tick + 4'd1;
          if (rx_tick == 4'd15) begin
            if (rx_s) begin
              rx_data <= rx_shift;
              rx_done <= 1'b1;
            end
            rx_busy  <= 1'b0;
            rx_state <= S_IDLE;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transceiver.sv
// tb/tb_uart_transceiver.sv - scoreboard bench for uart_transceiver
`timescale 1ns/1ps
module tb_uart_transceiver;
  // Scaled clock so one bit is 128 clocks (TICK_DIV = 8).
  localparam int CLK_FREQ = 1_228_800;
  localparam int BAUD     = 9600;
  localparam int TD       = 8;
  localparam int BIT      = 16 * TD;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tb_tx_start = 1'b0;
  logic [7:0] tb_tx_data = 8'h00;
  logic       loop_en = 1'b0;
  logic       rx = 1'b1;
  logic       tx, tx_busy, rx_busy, rx_done;
  logic [7:0] rx_data;
  logic       tx_start;
  logic [7:0] tx_data;

  assign tx_start = loop_en ? rx_done : tb_tx_start;
  assign tx_data  = loop_en ? rx_data : tb_tx_data;

  uart_transceiver #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk(clk), .reset(reset), .tx_start(tx_start), .tx_data(tx_data), .rx(rx),
    .tx(tx), .tx_busy(tx_busy), .rx_data(rx_data), .rx_busy(rx_busy), .rx_done(rx_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int rx_done_cnt = 0;
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop, input int stop_len);
    @(posedge clk); #1; rx = 1'b0;
    repeat (BIT) @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT) @(posedge clk);
      #1;
    end
    rx = stop;
    repeat (stop_len) @(posedge clk);
    #1; rx = 1'b1;
  endtask

  // RX side of the scoreboard
  initial forever begin
    @(negedge clk);
    if (rx_done === 1'b1) begin
      rx_done_cnt++;
      if (exp_rx.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rx_unexpected_done: got 0x%0h expected no strobe", rx_data);
      end else begin
        chk("rx_data", rx_data, exp_rx.pop_front());
      end
    end
  end

  // TX side: decode frames on tx at mid-bit; frames cut by reset are dropped
  initial begin : tx_mon
    logic [9:0] f;
    bit         ab;
    forever begin
      @(negedge clk iff (tx === 1'b0));
      ab = (reset == 1'b0);
      for (int k = 0; k < 10; k++) begin
        repeat ((k == 0) ? BIT / 2 : BIT) begin
          @(negedge clk);
          if (!reset) ab = 1'b1;
        end
        f[k] = tx;
      end
      if (!ab) begin
        if (exp_tx.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL tx_unexpected_frame: got 0x%0h expected no frame", f[8:1]);
        end else begin
          chk("tx_start_bit", f[0], 0);
          chk("tx_data", f[8:1], exp_tx.pop_front());
          chk("tx_stop_bit", f[9], 1);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int   busy_cnt, cnt0, rise, fall;
    logic prev;
    int   edges[$];

    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("reset_tx", tx, 1);
    chk("reset_tx_busy", tx_busy, 0);
    chk("reset_rx_busy", rx_busy, 0);
    chk("reset_rx_done", rx_done, 0);
    chk("reset_rx_data", rx_data, 8'h00);
    reset = 1'b1;
    repeat (20) @(posedge clk);

    // Loopback echo of 0x30
    loop_en = 1'b1;
    cnt0 = rx_done_cnt;
    exp_rx.push_back(8'h30);
    exp_tx.push_back(8'h30);
    send_byte(8'h30, 1'b1, BIT);
    repeat (12 * BIT) @(posedge clk);
    chk("loop_rx_done_count", rx_done_cnt - cnt0, 1);
    chk("loop_rx_data", rx_data, 8'h30);
    loop_en = 1'b0;

    // Direct 0x55 with an ignored second request mid-frame
    exp_tx.push_back(8'h55);
    @(posedge clk); #1; tb_tx_data = 8'h55; tb_tx_start = 1'b1;
    @(posedge clk); #1; tb_tx_start = 1'b0;
    busy_cnt = 0;
    prev = 1'b1;
    for (int c = 0; c < 12 * BIT; c++) begin
      @(negedge clk);
      if (tx_busy) busy_cnt++;
      if (tx !== prev) begin
        edges.push_back(c);
        prev = tx;
      end
      if (c == 5 * BIT) begin
        tb_tx_data = 8'hAA;
        tb_tx_start = 1'b1;
      end
      if (c == 5 * BIT + 1) tb_tx_start = 1'b0;
    end
    chk_range("tx55_busy_width", busy_cnt, 10 * BIT - TD, 10 * BIT + TD);
    chk("tx55_edge_count", edges.size(), 10);
    for (int i = 1; i < 10; i++)
      if (i < edges.size()) chk_range("tx55_bit_width", edges[i] - edges[i-1], BIT - TD, BIT + TD);

    // Short glitch on rx
    cnt0 = rx_done_cnt;
    rise = -1;
    fall = -1;
    for (int c = 0; c < 2 * BIT; c++) begin
      @(negedge clk);
      if (c == 0) rx = 1'b0;
      if (c == 4) rx = 1'b1;
      if (rx_busy && rise < 0) rise = c;
      if (!rx_busy && rise >= 0 && fall < 0) fall = c;
    end
    chk("glitch_busy_rose", rise >= 0, 1);
    chk_range("glitch_busy_fall_cycle", fall, 7 * TD, 9 * TD + 2);
    chk("glitch_no_done", rx_done_cnt - cnt0, 0);
    chk("glitch_rx_data_kept", rx_data, 8'h30);

    // Framing error then a good frame, echoed
    loop_en = 1'b1;
    cnt0 = rx_done_cnt;
    send_byte(8'hA5, 1'b0, 12 * TD);
    repeat (2 * BIT) @(posedge clk);
    chk("frame_err_no_done", rx_done_cnt - cnt0, 0);
    chk("frame_err_rx_data_kept", rx_data, 8'h30);
    exp_rx.push_back(8'h3C);
    exp_tx.push_back(8'h3C);
    send_byte(8'h3C, 1'b1, BIT);
    repeat (12 * BIT) @(posedge clk);
    chk("after_err_done_count", rx_done_cnt - cnt0, 1);
    chk("after_err_rx_data", rx_data, 8'h3C);
    loop_en = 1'b0;

    // Reset during data bit 4 of 0x0F (bit 4 is 0)
    @(posedge clk); #1; tb_tx_data = 8'h0F; tb_tx_start = 1'b1;
    @(posedge clk); #1; tb_tx_start = 1'b0;
    repeat (5 * BIT + BIT / 2) @(posedge clk);
    #1;
    chk("pre_reset_tx_bit4", tx, 0);
    chk("pre_reset_tx_busy", tx_busy, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("reset_mid_tx", tx, 1);
    chk("reset_mid_tx_busy", tx_busy, 0);
    reset = 1'b1;
    repeat (12 * BIT) @(posedge clk);

    exp_tx.push_back(8'hFF);
    @(posedge clk); #1; tb_tx_data = 8'hFF; tb_tx_start = 1'b1;
    @(posedge clk); #1; tb_tx_start = 1'b0;
    repeat (12 * BIT) @(posedge clk);
    #1;
    chk("ff_tx_busy_cleared", tx_busy, 0);
    chk("ff_tx_idle", tx, 1);

    chk("tx_queue_drained", exp_tx.size(), 0);
    chk("rx_queue_drained", exp_rx.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
